windowed_energy: RTL and testbench

// Parametrised sliding-window energy detector for the Schmidl-Cox timing path.

---
 rtl/windowed_energy_if.sv | 26 ++
 rtl/windowed_energy.sv | 149 ++++++++++++++
 tb/tb_windowed_energy.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/windowed_energy_if.sv
// Stream bundle for windowed_energy: sample input stream and energy output stream.
// The slave modport is the detector side; the master modport is the source/sink side.
interface windowed_energy_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 16
);
    logic [2*WIDTH-1:0]   i_tdata;
    logic                 i_tlast;
    logic                 i_tvalid;
    logic                 i_tready;
    logic [OUT_WIDTH-1:0] o_tdata;
    logic                 o_tlast;
    logic                 o_tuser;
    logic                 o_tvalid;
    logic                 o_tready;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tuser, o_tvalid
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tuser, o_tvalid
    );
endinterface

// File: rtl/windowed_energy.sv
// Sliding-window |x|^2 energy detector: magsq stage, then a circular-buffer
// running sum with run-time window length, right shift and output saturation.
module windowed_energy #(
    parameter int WIDTH     = 16,
    parameter int MAX_LEN   = 1024,
    parameter int OUT_WIDTH = 16,
    localparam int LEN_W    = $clog2(MAX_LEN + 1),
    localparam int ACC_W    = 2*WIDTH + LEN_W,
    localparam int SH_W     = $clog2(ACC_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [LEN_W-1:0] len,
    input  logic [SH_W-1:0]  shift,
    windowed_energy_if.slave s
);
    localparam int MW    = 2*WIDTH;
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    function automatic logic [OUT_WIDTH-1:0] sat_out(input logic [ACC_W-1:0] v);
        if (|v[ACC_W-1:OUT_WIDTH]) begin
            sat_out = '1;
        end else begin
            sat_out = v[OUT_WIDTH-1:0];
        end
    endfunction

    function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] l);
        if (l == {LEN_W{1'b0}}) begin
            clip_len = LEN_W'(1);
        end else if (l > MAX_LEN_C) begin
            clip_len = MAX_LEN_C;
        end else begin
            clip_len = l;
        end
    endfunction

    logic                    en_s, flush_s, accept_s, upd_s, wrap_s;
    logic signed [WIDTH-1:0] i_s, q_s;
    logic signed [MW-1:0]    i_ext_s, q_ext_s, ii_s, qq_s;
    logic [MW-1:0]           magsq_s, leave_s;
    logic [LEN_W-1:0]        len_use_s, fill_nx_s;
    logic [PTR_W-1:0]        wptr_nx_s;
    logic [ACC_W-1:0]        acc_nx_s;

    logic                    s1_valid_r, s1_last_r;
    logic [MW-1:0]           s1_magsq_r;
    logic [MW-1:0]           buf_r [MAX_LEN];
    logic [PTR_W-1:0]        wptr_r;
    logic [LEN_W-1:0]        fill_r, len_r;
    logic [ACC_W-1:0]        acc_r;
    logic [OUT_WIDTH-1:0]    o_tdata_r;
    logic                    o_tlast_r, o_tuser_r, o_tvalid_r;

    // Handshake, flush detection and squared magnitude of the incoming sample.
    always_comb begin
        en_s     = !o_tvalid_r || s.o_tready;
        flush_s  = clear || (len != len_r);
        accept_s = s.i_tvalid && en_s && !clear;
        upd_s    = en_s && s1_valid_r && !flush_s && !reset;
        i_s      = s.i_tdata[MW-1:WIDTH];
        q_s      = s.i_tdata[WIDTH-1:0];
        i_ext_s  = MW'(i_s);
        q_ext_s  = MW'(q_s);
        ii_s     = i_ext_s * i_ext_s;
        qq_s     = q_ext_s * q_ext_s;
        magsq_s  = $unsigned(ii_s) + $unsigned(qq_s);
    end

    // Window arithmetic: the leaving term is masked until the window is full.
    always_comb begin
        len_use_s = clip_len(len_r);
        if (fill_r >= len_use_s) begin
            leave_s = buf_r[wptr_r];
        end else begin
            leave_s = {MW{1'b0}};
        end
        wrap_s = (LEN_W'(wptr_r) + LEN_W'(1)) >= len_use_s;
        if (wrap_s) begin
            wptr_nx_s = {PTR_W{1'b0}};
        end else begin
            wptr_nx_s = wptr_r + PTR_W'(1);
        end
        if (fill_r < len_use_s) begin
            fill_nx_s = fill_r + LEN_W'(1);
        end else begin
            fill_nx_s = fill_r;
        end
        acc_nx_s = acc_r + ACC_W'(s1_magsq_r) - ACC_W'(leave_s);
    end

    assign s.i_tready = en_s && !reset;
    assign s.o_tdata  = o_tdata_r;
    assign s.o_tlast  = o_tlast_r;
    assign s.o_tuser  = o_tuser_r;
    assign s.o_tvalid = o_tvalid_r;

    // Registered copy of len, used to detect run-time length changes.
    always_ff @(posedge clk) begin
        len_r <= len;
    end

    // Stage 1: registered magsq; a flush keeps only the sample accepted with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_magsq_r <= {MW{1'b0}};
            s1_last_r  <= 1'b0;
        end else if (flush_s || en_s) begin
            s1_valid_r <= accept_s;
            s1_magsq_r <= magsq_s;
            s1_last_r  <= s.i_tlast;
        end
    end

    // Circular buffer of past magsq values; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (upd_s) begin
            buf_r[wptr_r] <= s1_magsq_r;
        end
    end

    // Stage 2: running sum, fill tracking and the output register.
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            acc_r      <= {ACC_W{1'b0}};
            fill_r     <= {LEN_W{1'b0}};
            wptr_r     <= {PTR_W{1'b0}};
            o_tdata_r  <= {OUT_WIDTH{1'b0}};
            o_tlast_r  <= 1'b0;
            o_tuser_r  <= 1'b0;
            o_tvalid_r <= 1'b0;
        end else if (en_s) begin
            if (s1_valid_r) begin
                acc_r      <= acc_nx_s;
                fill_r     <= fill_nx_s;
                wptr_r     <= wptr_nx_s;
                o_tdata_r  <= sat_out(acc_nx_s >> shift);
                o_tlast_r  <= s1_last_r;
                o_tuser_r  <= (fill_nx_s == len_use_s);
                o_tvalid_r <= 1'b1;
            end else begin
                o_tvalid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_windowed_energy.sv
// Directed bench for windowed_energy: hand-computed vectors plus a window-sum
// model for the random backpressure run.
module tb_windowed_energy;
    logic        clk = 1'b0;
    logic        reset, clear;
    logic [10:0] len;
    logic [5:0]  shift;

    always #5 clk = ~clk;

    windowed_energy_if #(.WIDTH(16), .OUT_WIDTH(16)) ifc ();

    windowed_energy #(.WIDTH(16), .MAX_LEN(1024), .OUT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .len(len), .shift(shift), .s(ifc.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;
    longint unsigned hist[$];
    longint unsigned exp_d[$];
    logic            exp_u[$];
    logic            exp_l[$];
    longint unsigned obs_d[$];
    logic            obs_u[$];
    int cyc = 0, first_acc = -1, first_out = -1, prev_len = 4;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint unsigned msq(input logic [31:0] d);
        longint si, sq;
        si = longint'($signed(d[31:16]));
        sq = longint'($signed(d[15:0]));
        return $unsigned(si*si + sq*sq);
    endfunction

    // One clock: drive at negedge, check and model just after, before posedge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic rdy,
                         input logic clr, input int ln, input int sh, output logic acc);
        longint unsigned sum;
        int L;
        @(negedge clk);
        ifc.i_tvalid = v; ifc.i_tdata = d; ifc.i_tlast = l; ifc.o_tready = rdy;
        clear = clr; len = 11'(ln); shift = 6'(sh);
        #1;
        chk("i_tready", ifc.i_tready, !ifc.o_tvalid || rdy);
        if (ifc.o_tvalid && first_out < 0) first_out = cyc;
        if (ifc.o_tvalid && rdy) begin
            obs_d.push_back(ifc.o_tdata);
            obs_u.push_back(ifc.o_tuser);
            chk("output_expected", exp_d.size() > 0, 1);
            if (exp_d.size() > 0) begin
                chk("o_tdata", ifc.o_tdata, exp_d.pop_front());
                chk("o_tuser", ifc.o_tuser, exp_u.pop_front());
                chk("o_tlast", ifc.o_tlast, exp_l.pop_front());
            end
        end
        if (clr || ln != prev_len) begin
            hist.delete(); exp_d.delete(); exp_u.delete(); exp_l.delete();
        end
        prev_len = ln;
        acc = v && ifc.i_tready && !clr;
        if (acc) begin
            if (first_acc < 0) first_acc = cyc;
            L = (ln == 0) ? 1 : (ln > 1024) ? 1024 : ln;
            hist.push_back(msq(d));
            while (hist.size() > L) void'(hist.pop_front());
            sum = 0;
            foreach (hist[k]) sum += hist[k];
            sum = sum >> sh;
            if (sum > 65535) sum = 65535;
            exp_d.push_back(sum);
            exp_u.push_back(hist.size() == L);
            exp_l.push_back(l);
        end
        cyc++;
    endtask

    task automatic drain(input int ln, input int sh);
        logic a;
        repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, ln, sh, a);
        chk("drain_empty", exp_d.size(), 0);
    endtask

    task automatic start_test();
        obs_d.delete(); obs_u.delete();
        first_acc = -1; first_out = -1;
    endtask

    task automatic check_obs(input string tag, input int i, input longint unsigned d, input logic u);
        chk(tag, obs_d[i], d);
        chk({tag, "_user"}, obs_u[i], u);
    endtask

    logic        a, v;
    logic [31:0] d;
    int          idx, guard;
    longint unsigned t1 [6] = '{10000, 20000, 30000, 40000, 40000, 40000};
    logic            u1 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        reset = 1'b1; clear = 1'b0; len = 11'd4; shift = 6'd0;
        ifc.i_tvalid = 1'b0; ifc.i_tdata = 32'h0; ifc.i_tlast = 1'b0; ifc.o_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_o_tvalid", ifc.o_tvalid, 0);
        chk("rst_o_tdata", ifc.o_tdata, 0);
        chk("rst_o_tuser", ifc.o_tuser, 0);
        chk("rst_o_tlast", ifc.o_tlast, 0);
        ifc.i_tvalid = 1'b1;
        #1;
        chk("rst_i_tready", ifc.i_tready, 0);
        ifc.i_tvalid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Test 1: constant (100,0), len 4
        start_test();
        for (int k = 0; k < 6; k++) cycle(1'b1, {16'd100, 16'd0}, k == 5, 1'b1, 1'b0, 4, 0, a);
        drain(4, 0);
        chk("t1_count", obs_d.size(), 6);
        for (int k = 0; k < 6; k++) check_obs("t1_data", k, t1[k], u1[k]);
        chk("t1_latency", first_out - first_acc, 2);

        // Test 2: saturation at full-scale (32767,32767)
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4, 0, a);
        start_test();
        for (int k = 0; k < 4; k++) cycle(1'b1, {16'sd32767, 16'sd32767}, 1'b0, 1'b1, 1'b0, 4, 0, a);
        drain(4, 0);
        chk("t2_count", obs_d.size(), 4);
        for (int k = 0; k < 4; k++) check_obs("t2_sat", k, 65535, k == 3);

        // Test 3: (-32768,0), len 8, shift 18 -> k*4096
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8, 18, a);
        start_test();
        for (int k = 0; k < 8; k++) cycle(1'b1, {16'h8000, 16'h0000}, 1'b0, 1'b1, 1'b0, 8, 18, a);
        drain(8, 18);
        chk("t3_count", obs_d.size(), 8);
        for (int k = 0; k < 8; k++) check_obs("t3_shift", k, 4096 * (k + 1), k == 7);

        // Test 4: random stream, random backpressure and a 10-cycle stall, len 17
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 17, 18, a);
        start_test();
        idx = 0; guard = 0; v = 1'b0; d = $urandom();
        while (idx < 2000 && guard < 20000) begin
            if (idx == 1000) begin
                for (int k = 0; k < 10; k++) begin
                    cycle(1'b1, d, d[0], 1'b0, 1'b0, 17, 18, a);
                    if (a) begin idx++; d = $urandom(); end
                end
                chk("t4_stall_ready", ifc.i_tready, 0);
            end
            if (!v) v = ($urandom_range(0, 9) < 8);
            cycle(v, d, d[0], 1'($urandom_range(0, 1)), 1'b0, 17, 18, a);
            if (a) begin idx++; d = $urandom(); v = 1'b0; end
            guard++;
        end
        chk("t4_no_timeout", guard < 20000, 1);
        drain(17, 18);
        chk("t4_count", obs_d.size(), 2000);

        // Test 5: len 4 steady, then len 2 restarts the window
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4, 0, a);
        start_test();
        for (int k = 0; k < 6; k++) cycle(1'b1, {16'd10, 16'd0}, 1'b0, 1'b1, 1'b0, 4, 0, a);
        cycle(1'b1, {16'd3, 16'd4}, 1'b0, 1'b1, 1'b0, 2, 0, a);
        cycle(1'b1, {16'd6, 16'd8}, 1'b0, 1'b1, 1'b0, 2, 0, a);
        drain(2, 0);
        chk("t5_count", obs_d.size(), 7);
        check_obs("t5_pre", 4, 400, 1'b1);
        check_obs("t5_new1", 5, 25, 1'b0);
        check_obs("t5_new2", 6, 125, 1'b1);

        // Test 6: clear with the pipeline full and the output stalled
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4, 0, a);
        start_test();
        for (int k = 0; k < 5; k++) cycle(1'b1, {16'd10, 16'd0}, 1'b0, 1'b1, 1'b0, 4, 0, a);
        cycle(1'b1, {16'd10, 16'd0}, 1'b0, 1'b0, 1'b1, 4, 0, a);
        chk("t6_clear_discards", a, 0);
        cycle(1'b1, {16'd0, 16'd5}, 1'b1, 1'b1, 1'b0, 4, 0, a);
        drain(4, 0);
        chk("t6_count", obs_d.size(), 4);
        check_obs("t6_pre", 2, 300, 1'b0);
        check_obs("t6_new", 3, 25, 1'b0);

        // Test 7: len 0 behaves as a one-sample window
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0, a);
        start_test();
        cycle(1'b1, {16'd3, 16'd4}, 1'b0, 1'b1, 1'b0, 0, 0, a);
        cycle(1'b1, {16'd6, 16'd8}, 1'b0, 1'b1, 1'b0, 0, 0, a);
        drain(0, 0);
        chk("t7_count", obs_d.size(), 2);
        check_obs("t7_a", 0, 25, 1'b1);
        check_obs("t7_b", 1, 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
